// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver block.
//   rx_state_t      : receive FSM states
//   DATA_BITS       : payload bits per 8N1 frame
//   MIN_DIV_DEFAULT : smallest usable cycles-per-bit divisor
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DATA_BITS       = 8;
    localparam int MIN_DIV_DEFAULT = 4;

endpackage

// File: rtl/rx_sync_fifo.sv
// Show-ahead synchronous FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (dropped when full unless a pop happens too)
//   pop        : remove head (ignored when empty)
//   head       : current head entry, meaningful while empty=0
//   empty/full : occupancy flags
module rx_sync_fifo
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_pop_s;
    logic             do_push_s;

    // Pointers carry one extra wrap bit so equal indices can be told apart as empty or full.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array and read/write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, runtime divisor) feeding a show-ahead byte FIFO.
//   wb_clk_i/wb_rst_i : system clock, asynchronous active-high reset
//   rx_i              : raw serial line, idles high, asynchronous
//   clk_div           : clock cycles per bit, clamped to at least MIN_DIV
//   rd_en             : pop FIFO head (ignored while rx_valid=0)
//   err_clr           : clears frame_err and overrun (a same-cycle error wins)
//   rd_data/rx_valid  : FIFO head and not-empty
//   fifo_full         : FIFO holds FIFO_DEPTH bytes
//   frame_err/overrun : sticky error flags
//   irq               : rx_valid | frame_err | overrun
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int MIN_DIV    = MIN_DIV_DEFAULT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             rx_i,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [7:0]       rd_data,
    output logic             rx_valid,
    output logic             fifo_full,
    output logic             frame_err,
    output logic             overrun,
    output logic             irq
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [1:0]           rst_sync_r;
    logic                 rst_s;
    logic                 sync1_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    logic [1:0]           fill_r;
    logic                 arm_r;
    logic                 fall_s;

    rx_state_t            state_r, state_s;
    logic [DIV_W-1:0]     cnt_r, cnt_s;
    logic [DIV_W-1:0]     div_r, div_s;
    logic [DIV_W-1:0]     div_eff_s;
    logic [BIT_W-1:0]     bit_idx_r, bit_idx_s;
    logic [DATA_BITS-1:0] shreg_r, shreg_s;
    logic                 expire_s;
    logic                 push_s;
    logic                 ferr_set_s;
    logic                 ovr_set_s;
    logic                 pop_s;
    logic                 empty_s;
    logic                 frame_err_r;
    logic                 overrun_r;

    // Reset asserts immediately but releases two clocks later, aligned to the clock.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rst_sync_r <= 2'b11;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b0};
        end
    end
    assign rst_s = rst_sync_r[1];

    // Two-flop line synchronizer plus edge-detect history; presets to the idle level.
    // arm_r only sets once a genuinely sampled high level has been seen, so a line
    // that is low when reset releases cannot masquerade as a start edge.
    always_ff @(posedge wb_clk_i or posedge rst_s) begin
        if (rst_s) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
            fill_r    <= 2'b00;
            arm_r     <= 1'b0;
        end else begin
            sync1_r   <= rx_i;
            rx_sync_r <= sync1_r;
            rx_prev_r <= rx_sync_r;
            fill_r    <= {fill_r[0], 1'b1};
            arm_r     <= arm_r | (fill_r[1] & rx_sync_r);
        end
    end

    assign fall_s    = arm_r & rx_prev_r & ~rx_sync_r;
    assign div_eff_s = (clk_div < DIV_MIN) ? DIV_MIN : clk_div;
    // Loading N and expiring at 1 gives exactly N cycles per interval.
    assign expire_s  = (cnt_r <= DIV_ONE);

    // FSM state and datapath registers.
    always_ff @(posedge wb_clk_i or posedge rst_s) begin
        if (rst_s) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            div_r     <= DIV_MIN;
            bit_idx_r <= '0;
            shreg_r   <= '0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            div_r     <= div_s;
            bit_idx_r <= bit_idx_s;
            shreg_r   <= shreg_s;
        end
    end

    // Next-state logic: START waits half a bit to land on bit centres, then full bits.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        div_s      = div_r;
        bit_idx_s  = bit_idx_r;
        shreg_s    = shreg_r;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_s = START;
                    div_s   = div_eff_s;
                    cnt_s   = div_eff_s >> 1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (expire_s) begin
                    if (rx_sync_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s   = DATA;
                        bit_idx_s = '0;
                        cnt_s     = div_r;
                    end
                end else begin
                    cnt_s = cnt_r - DIV_ONE;
                end
            end
            DATA: begin
                if (expire_s) begin
                    shreg_s = {rx_sync_r, shreg_r[DATA_BITS-1:1]};
                    cnt_s   = div_r;
                    if (bit_idx_r == BIT_LAST) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + BIT_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r - DIV_ONE;
                end
            end
            STOP: begin
                if (expire_s) begin
                    if (rx_sync_r) begin
                        push_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        ferr_set_s = 1'b1;
                        state_s    = BREAK;
                    end
                end else begin
                    cnt_s = cnt_r - DIV_ONE;
                end
            end
            BREAK: begin
                if (rx_sync_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign pop_s     = rd_en & ~empty_s;
    // A full FIFO only drops the byte when no pop is freeing a slot in the same cycle.
    assign ovr_set_s = push_s & fifo_full & ~pop_s;

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge wb_clk_i or posedge rst_s) begin
        if (rst_s) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (err_clr) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (err_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    rx_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (rst_s),
        .push      (push_s),
        .push_data (shreg_r),
        .pop       (rd_en),
        .head      (rd_data),
        .empty     (empty_s),
        .full      (fifo_full)
    );

    assign rx_valid  = ~empty_s;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign irq       = rx_valid | frame_err_r | overrun_r;

endmodule
